// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the byte-framed register bus master.
package reg_bus_pkg;

  localparam int ADDR_W     = 31;
  localparam int DATA_W     = 32;
  localparam int OP_BIT     = 7;
  localparam int ADDR_BYTES = 3;
  localparam int DATA_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WR,
    S_RD,
    S_RWAIT,
    S_RESP
  } state_t;

  // States in which a host byte may be taken.
  function automatic logic accepts_rx(state_t s);
    return (s == S_IDLE) || (s == S_ADDR) || (s == S_WDATA);
  endfunction

endpackage

// File: rtl/reg_bus_ser.sv
// Response serialiser: loads up to four bytes of a word and sends them MSB first
// over a valid/ready byte link.
module reg_bus_ser (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [2:0]  count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [23:0] rest;
  logic [2:0]  left;

  assign done = tx_valid && tx_ready && (left == 3'd1);

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rest     <= 24'h0;
      left     <= 3'd0;
    end else if (load) begin
      tx_data  <= word[31:24];
      rest     <= word[23:0];
      left     <= count;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      left <= left - 3'd1;
      if (left == 3'd1) begin
        tx_valid <= 1'b0;
        tx_data  <= 8'h00;
      end else begin
        tx_data <= rest[23:16];
        rest    <= {rest[15:0], 8'h00};
      end
    end
  end

endmodule

// File: rtl/reg_bus_master.sv
// Parses host command frames into single-cycle register bus reads/writes and
// returns an ack byte (write) or the 32-bit read value (read).
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE   = 8'hA5,
  parameter int         RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_bus_wr,
  input  logic [DATA_W-1:0] data_bus_rd,
  output logic              wr_strobe,
  output logic              rd_strobe
);

  state_t            state;
  logic [1:0]        cnt;
  logic              is_wr;
  logic [ADDR_W-1:0] addr_sh;
  logic [23:0]       data_sh;
  logic [7:0]        lat_cnt;
  logic              rx_fire;
  logic              ser_load;
  logic [31:0]       ser_word;
  logic [2:0]        ser_count;
  logic              ser_done;

  assign rx_ready  = reset_n && accepts_rx(state);
  assign rx_fire   = rx_valid && rx_ready;
  assign ser_load  = (state == S_WR) || ((state == S_RWAIT) && (lat_cnt == 8'd0));
  assign ser_word  = (state == S_WR) ? {ACK_BYTE, 24'h0} : data_bus_rd;
  assign ser_count = (state == S_WR) ? 3'd1 : 3'(DATA_BYTES);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      is_wr       <= 1'b0;
      addr_sh     <= '0;
      data_sh     <= '0;
      lat_cnt     <= 8'd0;
      addr_bus    <= '0;
      data_bus_wr <= '0;
      wr_strobe   <= 1'b0;
      rd_strobe   <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle, so a set can only last one clock.
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      case (state)
        S_IDLE: if (rx_fire) begin
          is_wr   <= rx_data[OP_BIT];
          addr_sh <= {24'h0, rx_data[6:0]};
          cnt     <= 2'd0;
          state   <= S_ADDR;
        end
        S_ADDR: if (rx_fire) begin
          addr_sh <= {addr_sh[ADDR_W-9:0], rx_data};
          if (cnt == 2'(ADDR_BYTES - 1)) begin
            cnt <= 2'd0;
            if (is_wr) begin
              state <= S_WDATA;
            end else begin
              addr_bus  <= {addr_sh[ADDR_W-9:0], rx_data};
              rd_strobe <= 1'b1;
              state     <= S_RD;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_WDATA: if (rx_fire) begin
          data_sh <= {data_sh[15:0], rx_data};
          if (cnt == 2'(DATA_BYTES - 1)) begin
            cnt         <= 2'd0;
            addr_bus    <= addr_sh;
            data_bus_wr <= {data_sh, rx_data};
            wr_strobe   <= 1'b1;
            state       <= S_WR;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_WR: state <= S_RESP;
        S_RD: begin
          lat_cnt <= 8'(RD_LATENCY - 1);
          state   <= S_RWAIT;
        end
        // The serialiser captures data_bus_rd on the edge that leaves RWAIT.
        S_RWAIT: begin
          if (lat_cnt == 8'd0) state <= S_RESP;
          else lat_cnt <= lat_cnt - 8'd1;
        end
        S_RESP: if (ser_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  reg_bus_ser u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ser_load),
    .word     (ser_word),
    .count    (ser_count),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master: stimulus pushes expected strobes and
// response bytes; independent monitors pop and compare.
module tb_reg_bus_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [30:0] addr_bus;
  logic [31:0] data_bus_wr;
  logic [31:0] data_bus_rd = 32'h0;
  logic        wr_strobe;
  logic        rd_strobe;

  typedef struct {
    bit          is_wr;
    logic [30:0] addr;
    logic [31:0] data;
  } st_t;

  st_t         exp_st[$];
  logic [7:0]  exp_tx[$];
  st_t         mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_seen = 0;
  int          rd_seen = 0;
  bit          stall = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] rd_value = 32'h0;
  bit          tx_held = 1'b0;
  logic [7:0]  held_byte = 8'h00;
  bit          prev_strobe = 1'b0;

  reg_bus_master #(.ACK_BYTE(8'hA5), .RD_LATENCY(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .addr_bus    (addr_bus),
    .data_bus_wr (data_bus_wr),
    .data_bus_rd (data_bus_rd),
    .wr_strobe   (wr_strobe),
    .rd_strobe   (rd_strobe)
  );

  always #5 clk = ~clk;

  // Slave returns its value the cycle after the read strobe, 0 otherwise.
  always @(posedge clk) data_bus_rd <= rd_strobe ? rd_value : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Host side: ready always, or low for 10 cycles per presented byte.
  initial forever begin
    @(posedge clk); #1;
    if (!stall) tx_ready = 1'b1;
    else if (tx_ready) begin tx_ready = 1'b0; stall_cnt = 0; end
    else if (tx_valid) begin
      stall_cnt++;
      if (stall_cnt >= 10) tx_ready = 1'b1;
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (tx_valid && tx_held) check("tx_stable", 32'(tx_data), 32'(held_byte));
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_extra: got %h, want no byte", tx_data);
      end else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    tx_held   = tx_valid && !tx_ready;
    held_byte = tx_data;
  end

  // Bus strobe monitor.
  initial forever begin
    @(negedge clk);
    if (wr_strobe || rd_strobe) begin
      check("strobe_overlap", 32'(wr_strobe & rd_strobe), 32'd0);
      check("strobe_width", 32'(prev_strobe), 32'd0);
      if (wr_strobe) wr_seen++;
      if (rd_strobe) rd_seen++;
      if (exp_st.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL strobe_extra: got wr=%b rd=%b addr=%h, want none", wr_strobe, rd_strobe, addr_bus);
      end else begin
        mon_e = exp_st.pop_front();
        check("strobe_kind", 32'(wr_strobe), 32'(mon_e.is_wr));
        check("addr_bus", 32'(addr_bus), 32'(mon_e.addr));
        check("data_bus_wr", data_bus_wr, mon_e.data);
      end
    end
    prev_strobe = wr_strobe | rd_strobe;
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL rx_accept: byte %h not taken, want taken within 500 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [63:0] bytes, input int n, input int gap, input bit hold);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[63-8*i -: 8]);
      if (gap > 0 && i < n - 1) begin
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (!hold) rx_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_st.size() == 0 && rx_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d bytes and %0d strobes outstanding, want 0", exp_tx.size(), exp_st.size());
      exp_tx.delete();
      exp_st.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic push_st(input bit w, input logic [30:0] a, input logic [31:0] d);
    st_t e;
    e.is_wr = w; e.addr = a; e.data = d;
    exp_st.push_back(e);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[31-8*i -: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_rd_strobe", 32'(rd_strobe), 32'd0);
    check("rst_addr_bus", 32'(addr_bus), 32'd0);
    check("rst_data_bus_wr", data_bus_wr, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;

    // Basic write
    push_st(1'b1, 31'h01000005, 32'hDEADBEEF);
    exp_tx.push_back(8'hA5);
    send_frame(64'h81000005_DEADBEEF, 8, 0, 1'b0);
    drain();
    check("addr_hold", 32'(addr_bus), 32'h01000005);

    // Read with gaps between bytes; write data stays on the bus
    rd_value = 32'h00000005;
    push_st(1'b0, 31'h01000000, 32'hDEADBEEF);
    push_word(32'h00000005);
    send_frame(64'h01000000_00000000, 4, 3, 1'b0);
    drain();

    // Read returning zero still yields four bytes
    rd_value = 32'h00000000;
    push_st(1'b0, 31'h00123456, 32'hDEADBEEF);
    push_word(32'h00000000);
    send_frame(64'h00123456_00000000, 4, 0, 1'b0);
    drain();

    // Read with host stalling every byte
    stall = 1'b1;
    rd_value = 32'hCAFEF00D;
    push_st(1'b0, 31'h7FFFFFFF, 32'hDEADBEEF);
    push_word(32'hCAFEF00D);
    send_frame(64'h7FFFFFFF_00000000, 4, 0, 1'b0);
    drain();
    stall = 1'b0;

    // Reset after two bytes of a write, then a read
    send_frame(64'h81000000_00000000, 2, 0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    check("midrst_addr_bus", 32'(addr_bus), 32'd0);
    check("midrst_data_bus_wr", data_bus_wr, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_rx_ready_after", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rd_value = 32'h12345678;
    push_st(1'b0, 31'h02000010, 32'h00000000);
    push_word(32'h12345678);
    send_frame(64'h02000010_00000000, 4, 0, 1'b0);
    drain();

    // rx_valid pulsed while responding is ignored
    stall = 1'b1;
    push_st(1'b1, 31'h05000001, 32'h0000002A);
    exp_tx.push_back(8'hA5);
    send_frame(64'h85000001_0000002A, 8, 0, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    check("resp_started", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rx_data  = 8'h80;
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rx_ready_in_resp", 32'(rx_ready), 32'd0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    stall = 1'b0;
    drain();
    rd_value = 32'h0000002A;
    push_st(1'b0, 31'h05000001, 32'h0000002A);
    push_word(32'h0000002A);
    send_frame(64'h05000001_00000000, 4, 0, 1'b0);
    drain();

    // Back-to-back write then read with rx_valid held high
    rd_value = 32'hA1B2C3D4;
    push_st(1'b1, 31'h03000002, 32'h11223344);
    push_st(1'b0, 31'h03000002, 32'h11223344);
    exp_tx.push_back(8'hA5);
    push_word(32'hA1B2C3D4);
    send_frame(64'h83000002_11223344, 8, 0, 1'b1);
    send_frame(64'h03000002_00000000, 4, 0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    check("total_wr_strobes", 32'(wr_seen), 32'd3);
    check("total_rd_strobes", 32'(rd_seen), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 SHALL have parameter ACK_BYTE, default 8'hA5, byte returned after each completed write.
REQ-002 SHALL have parameter RD_LATENCY, default 1, cycles from rd_strobe cycle to data_bus_rd capture.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 rx_data  input  8  command byte from host link.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  block accepts rx_data; byte transfers when rx_valid && rx_ready at posedge.
REQ-008 tx_data  output  8  response byte to host link.
REQ-009 tx_valid  output  1  tx_data valid.
REQ-010 tx_ready  input  1  host accepts tx_data; byte transfers when tx_valid && tx_ready at posedge.
REQ-011 addr_bus  output  31  register address to all bus slaves.
REQ-012 data_bus_wr  output  32  write data to all bus slaves.
REQ-013 data_bus_rd  input  32  OR of all slave read outputs; unselected slaves drive 0.
REQ-014 wr_strobe  output  1  single-cycle write strobe.
REQ-015 rd_strobe  output  1  single-cycle read strobe.

Function
REQ-016 Frame byte 0: bit7 = 1 write / 0 read, bits 6:0 = addr[30:24]; bytes 1-3 = addr[23:0] MSB first; write frames add bytes 4-7 = data[31:0] MSB first.
REQ-017 States: IDLE (await byte 0), ADDR (3 bytes), WDATA (4 bytes), WR (strobe), RD (strobe), RWAIT (latency), RESP (transmit).
REQ-018 rx_ready SHALL be 1 exactly in IDLE, ADDR, WDATA; 0 otherwise.
REQ-019 IDLE->ADDR on byte-0 accept; ADDR->WDATA (write) or ->RD (read) on third address byte; WDATA->WR on fourth data byte.
REQ-020 addr_bus and data_bus_wr SHALL be loaded before the strobe cycle and held stable through it and until the next frame's strobe.
REQ-021 WR SHALL assert wr_strobe for exactly one cycle, then enter RESP with one byte ACK_BYTE.
REQ-022 RD SHALL assert rd_strobe for exactly one cycle; RWAIT SHALL capture data_bus_rd on the posedge RD_LATENCY cycles after the strobe cycle, then enter RESP with 4 bytes MSB first.
REQ-023 wr_strobe and rd_strobe SHALL never be high in the same cycle.
REQ-024 In RESP tx_valid SHALL be 1 and tx_data stable until accepted; tx_ready low stalls indefinitely without data loss.
REQ-025 After last response byte accepted, return to IDLE; rx_ready high the following cycle.
REQ-026 rx_valid during RESP/WR/RD/RWAIT SHALL be ignored (no accept, no state change).
REQ-027 Gaps (rx_valid low) between frame bytes SHALL be tolerated without timeout.
REQ-028 Captured read value 0 SHALL still produce 4 response bytes.

Reset
REQ-029 While reset_n = 0 at posedge: state IDLE, addr_bus 0, data_bus_wr 0, wr_strobe 0, rd_strobe 0, tx_valid 0, tx_data 0, byte counter 0.
REQ-030 Reset mid-frame or mid-response SHALL discard the partial frame/response; no strobe issued for it.
REQ-031 rx_ready SHALL be 0 during reset and 1 in the first cycle after reset_n rises.

Structure
REQ-032 Package reg_bus_pkg SHALL hold state enum, opcode bit position, address/data byte counts, bus widths (31/32).
REQ-033 One sub-module, reg_bus_ser (32-bit load, byte-out with valid/ready), SHALL implement RESP serialisation; parsing stays in reg_bus_master.

Verification
REQ-034 Write frame 81 00 00 05 DE AD BE EF -> addr_bus 31'h01000005, data_bus_wr 32'hDEADBEEF, one wr_strobe pulse, tx byte A5.
REQ-035 Read frame 01 00 00 00 with slave returning 32'h00000005 one cycle after strobe -> one rd_strobe pulse, tx bytes 00 00 00 05.
REQ-036 Read with tx_ready held low 10 cycles per byte -> tx_data stable while stalled, bytes unchanged, no extra strobes.
REQ-037 reset_n low after 2 bytes of a write frame, then full read frame -> no wr_strobe ever, correct read response only.
REQ-038 rx_valid pulsed during RESP -> rx_ready 0, byte not consumed, next frame parsed correctly.
REQ-039 Back-to-back write then read with rx_valid held high -> exactly one wr_strobe and one rd_strobe, never overlapping, responses A5 then 4 data bytes.
